// File: rtl/io_hub_pkg.sv
// io_hub_pkg: shared types and constants for the memory-mapped IO hub.
package io_hub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0]  IO_BASE_DEFAULT = 32'hFFFF_FC00;
  localparam int unsigned  CH_STRIDE       = 4;

  // Byte offset of the status register, just past the last channel.
  function automatic int unsigned stat_off(input int unsigned num_ch);
    return CH_STRIDE * num_ch;
  endfunction

endpackage

// File: rtl/io_hub_if.sv
// io_hub_if: request/acknowledge bus between the CPU load/store path and the IO hub.
interface io_hub_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              ack;
  logic              err;

  modport master (output req, we, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/io_sync.sv
// io_sync: W-bit two-flop synchroniser for asynchronous inputs.
module io_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // Two register stages to settle metastability before use.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_hub.sv
// io_hub: NUM_CH-channel memory-mapped IO hub with wait states, synchronised
// inputs and latched outputs. Optional input-change interrupt and status
// register are enabled by defining IO_HUB_EDGE_IRQ_EN.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int unsigned       NUM_CH   = 4,
  parameter int unsigned       DATA_W   = 24,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] IO_BASE  = ADDR_W'(IO_BASE_DEFAULT),
  parameter int unsigned       WAIT_CYC = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  io_hub_if.slave                  bus,
  input  logic [NUM_CH*DATA_W-1:0] io_in_i,
  output logic [NUM_CH*DATA_W-1:0] io_out_o
`ifdef IO_HUB_EDGE_IRQ_EN
  ,
  output logic                     irq_o
`endif
);

  localparam int unsigned       IO_W     = NUM_CH * DATA_W;
  localparam int unsigned       CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned       CNT_W    = 4;
  localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'((WAIT_CYC > 0) ? WAIT_CYC - 1 : 0);
  localparam logic [ADDR_W-1:0] STAT_OFF = ADDR_W'(stat_off(NUM_CH));

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [31:0]        rdata_q;
  logic               ack_q;
  logic               err_q;
  logic [IO_W-1:0]    io_out_q;
  logic [IO_W-1:0]    sync_c;

  logic               acc_we_c;
  logic [ADDR_W-1:0]  acc_addr_c;
  logic [ADDR_W-1:0]  off_c;
  logic [CH_W-1:0]    ch_c;
  logic               aligned_c;
  logic               hit_ch_c;
  logic               hit_stat_c;
  logic [DATA_W-1:0]  ch_rd_c;
  logic [31:0]        resp_rdata_c;
  logic               resp_err_c;
  logic               enter_resp_c;

`ifdef IO_HUB_EDGE_IRQ_EN
  logic [IO_W-1:0]    prev_q;
  logic [NUM_CH-1:0]  pending_q;
  logic [NUM_CH-1:0]  pending_d;
  logic [NUM_CH-1:0]  change_c;
  logic [NUM_CH-1:0]  clr_c;
  logic               irq_q;
`endif

  io_sync #(.W(IO_W)) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (io_in_i),
    .q_o (sync_c)
  );

  // Decode the access in flight: live bus fields in IDLE, captured ones after.
  always_comb begin
    acc_we_c   = (state_q == IDLE) ? bus.we   : we_q;
    acc_addr_c = (state_q == IDLE) ? bus.addr : addr_q;
    off_c      = acc_addr_c - IO_BASE;
    ch_c       = off_c[2 +: CH_W];
    aligned_c  = (acc_addr_c[1:0] == 2'b00);
    hit_ch_c   = aligned_c && (off_c < STAT_OFF);
`ifdef IO_HUB_EDGE_IRQ_EN
    hit_stat_c = aligned_c && (off_c == STAT_OFF);
`else
    hit_stat_c = 1'b0;
`endif
    ch_rd_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      if (ch_c == CH_W'(i)) ch_rd_c = sync_c[i*DATA_W +: DATA_W];
    end
    resp_err_c   = !(hit_ch_c || hit_stat_c);
    resp_rdata_c = '0;
    if (!acc_we_c && hit_ch_c) resp_rdata_c = 32'(ch_rd_c);
`ifdef IO_HUB_EDGE_IRQ_EN
    else if (!acc_we_c && hit_stat_c) resp_rdata_c = 32'(pending_q);
`endif
    enter_resp_c = ((state_q == IDLE) && bus.req && (WAIT_CYC == 0)) ||
                   ((state_q == WAIT) && (cnt_q == '0));
  end

  // Access FSM: capture in IDLE, count wait states, respond and write in RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      io_out_q <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (enter_resp_c) begin
        ack_q   <= 1'b1;
        err_q   <= resp_err_c;
        rdata_q <= resp_rdata_c;
      end
      unique case (state_q)
        IDLE: begin
          if (bus.req) begin
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            wdata_q <= DATA_W'(bus.wdata);
            if (WAIT_CYC > 0) begin
              state_q <= WAIT;
              cnt_q   <= CNT_INIT;
            end else begin
              state_q <= RESP;
            end
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - CNT_W'(1);
        end
        RESP: begin
          if (acc_we_c && hit_ch_c) begin
            for (int i = 0; i < int'(NUM_CH); i++) begin
              if (ch_c == CH_W'(i)) io_out_q[i*DATA_W +: DATA_W] <= wdata_q;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef IO_HUB_EDGE_IRQ_EN
  // Per-channel change detect; a new change beats a same-cycle status clear.
  always_comb begin
    change_c = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      change_c[i] = |(sync_c[i*DATA_W +: DATA_W] ^ prev_q[i*DATA_W +: DATA_W]);
    end
    clr_c = '0;
    if ((state_q == RESP) && !acc_we_c && hit_stat_c) clr_c = rdata_q[NUM_CH-1:0];
    pending_d = (pending_q & ~clr_c) | change_c;
  end

  // Previous-value, pending and interrupt registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      prev_q    <= sync_c;
      pending_q <= pending_d;
      irq_q     <= |pending_d;
    end
  end

  assign irq_o = irq_q;
`endif

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.err   = err_q;
  assign io_out_o  = io_out_q;

endmodule

// File: tb/tb_io_hub.sv
// tb_io_hub: directed scoreboard bench for io_hub (NUM_CH=4, DATA_W=24).
module tb_io_hub;
  import io_hub_pkg::*;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned DATA_W   = 24;
  localparam int unsigned WAIT_CYC = 1;
  localparam int unsigned IO_W     = NUM_CH * DATA_W;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [IO_W-1:0] io_in;
  logic [IO_W-1:0] io_out;
  logic [IO_W-1:0] io_in0;
  logic [IO_W-1:0] io_out0;
`ifdef IO_HUB_EDGE_IRQ_EN
  logic            irq;
  logic            irq0;
`endif

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  io_hub_if #(.ADDR_W(32)) bus ();
  io_hub_if #(.ADDR_W(32)) bus0 ();

  io_hub #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(32), .WAIT_CYC(WAIT_CYC)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .io_in_i  (io_in),
    .io_out_o (io_out)
`ifdef IO_HUB_EDGE_IRQ_EN
    ,
    .irq_o    (irq)
`endif
  );

  io_hub #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .ADDR_W(32), .WAIT_CYC(0)) dut0 (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus0),
    .io_in_i  (io_in0),
    .io_out_o (io_out0)
`ifdef IO_HUB_EDGE_IRQ_EN
    ,
    .irq_o    (irq0)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one access, queue its expected response, and check ack timing.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input logic tog);
    int lat;
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = we;
    bus.addr  = addr;
    bus.wdata = wdata;
    if (tog) io_in[3*DATA_W] = ~io_in[3*DATA_W];
    exp_q.push_back('{rdata: exp_rd, err: exp_err});
    @(negedge clk);
    bus.req = 1'b0;
    lat = 1;
    while (bus.ack !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    chk("ack_latency", 128'(lat), 128'(WAIT_CYC + 1));
    @(negedge clk);
    chk("ack_pulse", 128'(bus.ack), 128'(0));
  endtask

  // Monitor: pop and compare whenever the DUT acknowledges.
  always @(negedge clk) begin
    if (bus.ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("ack_unexpected", 128'(bus.ack), 128'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("rdata", 128'(bus.rdata), 128'(mon_e.rdata));
        chk("err", 128'(bus.err), 128'(mon_e.err));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]      pat;
    logic [IO_W-1:0] exp_io;
    int              waited;
    bus.req  = 1'b0; bus.we  = 1'b0; bus.addr  = '0; bus.wdata  = '0;
    bus0.req = 1'b0; bus0.we = 1'b0; bus0.addr = '0; bus0.wdata = '0;
    io_in  = '0;
    io_in0 = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_rdata",  128'(bus.rdata), 128'(0));
    chk("rst_ack",    128'(bus.ack),   128'(0));
    chk("rst_err",    128'(bus.err),   128'(0));
    chk("rst_io_out", 128'(io_out),    128'(0));
`ifdef IO_HUB_EDGE_IRQ_EN
    chk("rst_irq",    128'(irq),       128'(0));
`endif

    // Writes, including upper wdata bits that must be dropped.
    access(1'b1, 32'hFFFF_FC04, 32'h00AB_CDEF, 32'h0, 1'b0, 1'b0);
    exp_io = {24'h000000, 24'h000000, 24'hABCDEF, 24'h000000};
    chk("io_out_wr_ch1", 128'(io_out), 128'(exp_io));
    access(1'b1, 32'hFFFF_FC0C, 32'h5A11_2233, 32'h0, 1'b0, 1'b0);
    exp_io = {24'h112233, 24'h000000, 24'hABCDEF, 24'h000000};
    chk("io_out_wr_ch3", 128'(io_out), 128'(exp_io));

    // Synchronised read of channel 2.
    io_in[2*DATA_W +: DATA_W] = 24'h123456;
    repeat (3) @(negedge clk);
    access(1'b0, 32'hFFFF_FC08, 32'h0, 32'h0012_3456, 1'b0, 1'b0);
    access(1'b0, 32'hFFFF_FC00, 32'h0, 32'h0, 1'b0, 1'b0);

    // Misaligned and out-of-range accesses.
    access(1'b0, 32'hFFFF_FC02, 32'h0, 32'h0, 1'b1, 1'b0);
    access(1'b1, 32'hFFFF_FC06, 32'h00FF_FFFF, 32'h0, 1'b1, 1'b0);
    access(1'b0, 32'hFFFF_FBFC, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("io_out_after_err", 128'(io_out), 128'(exp_io));

`ifdef IO_HUB_EDGE_IRQ_EN
    // Channel 2 changed earlier, so status shows bit 2.
    access(1'b0, 32'hFFFF_FC10, 32'h0, 32'h0000_0004, 1'b0, 1'b0);
    chk("irq_after_clear", 128'(irq), 128'(0));
    io_in[3*DATA_W] = ~io_in[3*DATA_W];
    waited = 0;
    while (irq !== 1'b1 && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    chk("irq_rise", 128'(irq), 128'(1));
    access(1'b1, 32'hFFFF_FC10, 32'h0000_00FF, 32'h0, 1'b0, 1'b0);
    chk("irq_after_stat_wr", 128'(irq), 128'(1));
    access(1'b0, 32'hFFFF_FC10, 32'h0, 32'h0000_0008, 1'b0, 1'b1);
    chk("irq_set_wins", 128'(irq), 128'(1));
    access(1'b0, 32'hFFFF_FC10, 32'h0, 32'h0000_0008, 1'b0, 1'b0);
    chk("irq_drop", 128'(irq), 128'(0));
    access(1'b0, 32'hFFFF_FC10, 32'h0, 32'h0, 1'b0, 1'b0);
`else
    access(1'b0, 32'hFFFF_FC10, 32'h0, 32'h0, 1'b1, 1'b0);
    access(1'b1, 32'hFFFF_FC10, 32'h0000_0001, 32'h0, 1'b1, 1'b0);
`endif
    chk("io_out_after_stat", 128'(io_out), 128'(exp_io));

    // Zero-wait instance: req held for 6 cycles gives acks every other cycle.
    @(negedge clk);
    bus0.addr = 32'hFFFF_FC00;
    bus0.we   = 1'b0;
    bus0.req  = 1'b1;
    pat = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 5) bus0.req = 1'b0;
      pat = {pat[6:0], bus0.ack};
    end
    chk("thru_pattern", 128'(pat), 128'(8'b1010_1000));
    chk("thru_count", 128'($countones(pat)), 128'(3));

    // Reset during the wait state of a write drops it.
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'hFFFF_FC00;
    bus.wdata = 32'h0077_7777;
    @(negedge clk);
    bus.req = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_mid_no_ack", 128'(bus.ack), 128'(0));
    end
    chk("rst_mid_io_out", 128'(io_out), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_dropped", 128'(io_out), 128'(0));
    access(1'b1, 32'hFFFF_FC00, 32'h0000_0001, 32'h0, 1'b0, 1'b0);
    exp_io = {24'h000000, 24'h000000, 24'h000000, 24'h000001};
    chk("post_rst_write", 128'(io_out), 128'(exp_io));

    repeat (2) @(negedge clk);
    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
